// File: rtl/dvs_ravens_pkg.sv
// -----------------------------------------------------------------------------
// dvs_ravens_pkg
// Shared definitions for the DVS-to-RAVENS path and the RAVENS spike
// serializer.
//   RAVENS_PKT_BYTES : bytes per RAVENS spike packet
//   RAVENS_PKT_BITS  : packet width in bits
//   ravens_ser_state_t : serializer FSM state encoding
// -----------------------------------------------------------------------------
package dvs_ravens_pkg;

  localparam int RAVENS_PKT_BYTES = 4;
  localparam int RAVENS_PKT_BITS  = RAVENS_PKT_BYTES * 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ravens_ser_state_t;

endpackage : dvs_ravens_pkg

// File: rtl/ravens_pkt_fifo2.sv
// -----------------------------------------------------------------------------
// ravens_pkt_fifo2
// Two-entry circular packet FIFO with a registered occupancy count.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push_i     : write data_i at the write pointer (caller guarantees not full)
//   data_i     : packet to store
//   pop_i      : advance the read pointer (caller guarantees not empty)
//   head_o     : entry at the read pointer
//   count_o    : number of stored entries (0..2)
// -----------------------------------------------------------------------------
module ravens_pkt_fifo2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q,  count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push_i;
    rd_ptr_d = rd_ptr_q ^ pop_i;
    count_d  = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule : ravens_pkt_fifo2

// File: rtl/ravens_spike_serializer.sv
// -----------------------------------------------------------------------------
// ravens_spike_serializer
// Buffers up to two RAVENS spike packets and emits each one as a byte stream,
// MSB byte first, toward the RAVENS link transmitter. Counts completed packets.
//
// Handshakes (both interfaces): a transfer happens on a rising edge where
// valid & ready are both 1. The source holds valid and its data stable until
// the transfer; ready never depends combinationally on valid.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   spike_valid  : upstream packet valid
//   spike_pkt    : RAVENS spike packet
//   spike_ready  : a packet can be accepted this cycle (buffer not full)
//   tx_valid     : tx_byte is valid
//   tx_byte      : current output byte
//   tx_last      : tx_byte is the LSB (final) byte of its packet
//   tx_ready     : downstream accepts tx_byte this cycle
//   pkt_count    : packets fully transmitted (wraps)
//   busy         : buffer non-empty or serializer sending
// -----------------------------------------------------------------------------
module ravens_spike_serializer
  import dvs_ravens_pkg::*;
#(
  parameter int PKT_BYTES = RAVENS_PKT_BYTES,
  parameter int CNT_BITS  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   spike_valid,
  input  logic [PKT_BYTES*8-1:0] spike_pkt,
  output logic                   spike_ready,
  output logic                   tx_valid,
  output logic [7:0]             tx_byte,
  output logic                   tx_last,
  input  logic                   tx_ready,
  output logic [CNT_BITS-1:0]    pkt_count,
  output logic                   busy
);

  localparam int PKT_W = PKT_BYTES * 8;
  localparam int IDX_W = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_BYTES - 1);

  ravens_ser_state_t   state_q, state_d;
  logic [IDX_W-1:0]    idx_q,   idx_d;
  logic [PKT_W-1:0]    shift_q, shift_d;
  logic [CNT_BITS-1:0] cnt_q,   cnt_d;

  logic             push;
  logic             pop;
  logic [PKT_W-1:0] fifo_head;
  logic [1:0]       fifo_count;

  // Ready comes from the registered count only, so a pop in this cycle does
  // not open a slot until the next cycle.
  assign spike_ready = (fifo_count < 2'd2);
  assign push        = spike_valid & spike_ready;

  ravens_pkt_fifo2 #(
    .W (PKT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (spike_pkt),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_count != 2'd0) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          idx_d   = IDX_LAST;
          state_d = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (idx_q != '0) begin
            idx_d = idx_q - IDX_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_BITS'(1);
            // Reload directly from the buffer so consecutive packets leave
            // no idle cycle on the byte interface.
            if (fifo_count != 2'd0) begin
              pop     = 1'b1;
              shift_d = fifo_head;
              idx_d   = IDX_LAST;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode registered state only, so they hold while stalled.
  assign tx_valid  = (state_q == SEND);
  assign tx_byte   = tx_valid ? shift_q[idx_q*8 +: 8] : 8'h00;
  assign tx_last   = tx_valid & (idx_q == '0);
  assign pkt_count = cnt_q;
  assign busy      = (fifo_count != 2'd0) | (state_q == SEND);

endmodule : ravens_spike_serializer

// File: tb/tb_ravens_spike_serializer.sv
module tb_ravens_spike_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spike_valid = 1'b0;
  logic [31:0] spike_pkt = 32'h0;
  logic        tx_ready = 1'b0;

  logic        spike_ready, tx_valid, tx_last, busy;
  logic [7:0]  tx_byte;
  logic [15:0] pkt_count;

  logic        spike_ready_w, tx_valid_w, tx_last_w, busy_w;
  logic [7:0]  tx_byte_w;
  logic [3:0]  pkt_count_w;

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- clock / reset / DUTs ----------------
  always #5 clk = ~clk;

  ravens_spike_serializer dut (
    .clk         (clk),
    .rst         (rst),
    .spike_valid (spike_valid),
    .spike_pkt   (spike_pkt),
    .spike_ready (spike_ready),
    .tx_valid    (tx_valid),
    .tx_byte     (tx_byte),
    .tx_last     (tx_last),
    .tx_ready    (tx_ready),
    .pkt_count   (pkt_count),
    .busy        (busy)
  );

  // Narrow-counter instance sharing all inputs, used for the wrap check.
  ravens_spike_serializer #(.PKT_BYTES(4), .CNT_BITS(4)) dut_w (
    .clk         (clk),
    .rst         (rst),
    .spike_valid (spike_valid),
    .spike_pkt   (spike_pkt),
    .spike_ready (spike_ready_w),
    .tx_valid    (tx_valid_w),
    .tx_byte     (tx_byte_w),
    .tx_last     (tx_last_w),
    .tx_ready    (tx_ready),
    .pkt_count   (pkt_count_w),
    .busy        (busy_w)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pkt);
    spike_valid = 1'b1;
    spike_pkt   = pkt;
    step();
    spike_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
    n_cmp++; if (spike_ready !== 1'b1) begin n_fail++; $display("FAIL reset_spike_ready got %b want 1", spike_ready); end
    n_cmp++; if (pkt_count !== 16'd0) begin n_fail++; $display("FAIL reset_pkt_count got %0d want 0", pkt_count); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (tx_byte !== 8'h00 || tx_last !== 1'b0) begin n_fail++; $display("FAIL reset_tx_byte got %h/%b want 00/0", tx_byte, tx_last); end
    step();
    n_cmp++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_hold got valid %b busy %b want 0 0", tx_valid, busy); end
  endtask

  task automatic test_single();
    logic [31:0] pkt;
    logic [7:0]  exp_b [4];
    pkt = 32'hA1B2C3D4;
    exp_b[0] = 8'hA1; exp_b[1] = 8'hB2; exp_b[2] = 8'hC3; exp_b[3] = 8'hD4;
    tx_ready = 1'b1;
    push(pkt);
    n_cmp++; if (tx_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_latency got valid %b busy %b want 0 1", tx_valid, busy); end
    step();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (tx_valid !== 1'b1 || tx_byte !== exp_b[k] || tx_last !== (k == 3)) begin
        n_fail++;
        $display("FAIL single_byte%0d got v=%b b=%h l=%b want v=1 b=%h l=%b", k, tx_valid, tx_byte, tx_last, exp_b[k], (k == 3));
      end
      step();
    end
    n_cmp++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_done got valid %b busy %b want 0 0", tx_valid, busy); end
    n_cmp++; if (pkt_count !== 16'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", pkt_count); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
    tx_ready = 1'b0;
    push(32'h11223344);
    step();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (tx_valid !== 1'b1 || tx_byte !== 8'h11 || tx_last !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_stall%0d got v=%b b=%h l=%b want v=1 b=11 l=0", i, tx_valid, tx_byte, tx_last);
      end
      step();
    end
    tx_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (tx_valid !== 1'b1 || tx_byte !== exp_b[k] || tx_last !== (k == 3)) begin
        n_fail++;
        $display("FAIL bp_byte%0d got v=%b b=%h l=%b want v=1 b=%h l=%b", k, tx_valid, tx_byte, tx_last, exp_b[k], (k == 3));
      end
      step();
    end
    n_cmp++; if (tx_valid !== 1'b0 || pkt_count !== 16'd2) begin n_fail++; $display("FAIL bp_done got valid %b count %0d want 0 2", tx_valid, pkt_count); end
  endtask

  task automatic test_full_buffer();
    logic [7:0] exp_q [$];
    logic [7:0] exp_b;
    for (int k = 1; k <= 12; k++) exp_q.push_back(8'(k));
    tx_ready = 1'b0;
    spike_valid = 1'b1;
    spike_pkt = 32'h01020304; step();
    spike_pkt = 32'h05060708; step();
    spike_pkt = 32'h090A0B0C;
    n_cmp++; if (spike_ready !== 1'b1) begin n_fail++; $display("FAIL full_third_ready got %b want 1", spike_ready); end
    step();
    spike_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (spike_ready !== 1'b0 || busy !== 1'b1 || tx_valid !== 1'b1 || tx_byte !== 8'h01) begin
        n_fail++;
        $display("FAIL full_stall%0d got rdy=%b busy=%b v=%b b=%h want 0 1 1 01", i, spike_ready, busy, tx_valid, tx_byte);
      end
      step();
    end
    tx_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      exp_b = exp_q.pop_front();
      n_cmp++;
      if (tx_valid !== 1'b1 || tx_byte !== exp_b || tx_last !== ((k % 4) == 3) || spike_ready !== (k >= 4)) begin
        n_fail++;
        $display("FAIL full_byte%0d got v=%b b=%h l=%b rdy=%b want v=1 b=%h l=%b rdy=%b", k, tx_valid, tx_byte, tx_last, spike_ready, exp_b, ((k % 4) == 3), (k >= 4));
      end
      step();
    end
    n_cmp++; if (tx_valid !== 1'b0 || busy !== 1'b0 || pkt_count !== 16'd5) begin n_fail++; $display("FAIL full_done got v=%b busy=%b count=%0d want 0 0 5", tx_valid, busy, pkt_count); end
  endtask

  task automatic test_counter_wrap();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tx_ready = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      push(32'hC0DE0000 | 32'(i));
      for (int s = 0; s < 5; s++) step();
      if (i == 15 || i == 16 || i == 17) begin
        n_cmp++;
        if (tx_valid_w !== 1'b0 || pkt_count_w !== 4'(i % 16)) begin
          n_fail++;
          $display("FAIL wrap_after%0d got v=%b count=%0d want v=0 count=%0d", i, tx_valid_w, pkt_count_w, i % 16);
        end
      end
    end
    n_cmp++; if (pkt_count !== 16'd17) begin n_fail++; $display("FAIL wrap_wide_count got %0d want 17", pkt_count); end
  endtask

  task automatic test_reset_mid_packet();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h55; exp_b[1] = 8'h66; exp_b[2] = 8'h77; exp_b[3] = 8'h88;
    tx_ready = 1'b0;
    push(32'hDEADBEEF);
    step();
    n_cmp++; if (tx_byte !== 8'hDE || tx_valid !== 1'b1) begin n_fail++; $display("FAIL mid_first got v=%b b=%h want 1 de", tx_valid, tx_byte); end
    tx_ready = 1'b1;
    step();
    n_cmp++; if (tx_byte !== 8'hAD || tx_valid !== 1'b1) begin n_fail++; $display("FAIL mid_second got v=%b b=%h want 1 ad", tx_valid, tx_byte); end
    step();
    rst = 1'b1;
    tx_ready = 1'b0;
    step();
    rst = 1'b0;
    n_cmp++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || spike_ready !== 1'b1 || pkt_count !== 16'd0 || tx_byte !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset got v=%b busy=%b rdy=%b count=%0d b=%h want 0 0 1 0 00", tx_valid, busy, spike_ready, pkt_count, tx_byte);
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_resume%0d got v=%b b=%h want v=0", i, tx_valid, tx_byte); end
      step();
    end
    push(32'h55667788);
    step();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (tx_valid !== 1'b1 || tx_byte !== exp_b[k] || tx_last !== (k == 3)) begin
        n_fail++;
        $display("FAIL mid_new_byte%0d got v=%b b=%h l=%b want v=1 b=%h l=%b", k, tx_valid, tx_byte, tx_last, exp_b[k], (k == 3));
      end
      step();
    end
    n_cmp++; if (tx_valid !== 1'b0 || pkt_count !== 16'd1) begin n_fail++; $display("FAIL mid_new_done got v=%b count=%0d want 0 1", tx_valid, pkt_count); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_full_buffer();
    test_counter_wrap();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_ravens_spike_serializer
